// File: rtl/mem_fill_writer.sv
// mem_fill_writer: write-side companion to the operand memory.
// Single-word writes arrive on a valid/ready port and are buffered in a small FIFO. A fill
// command writes an incrementing data pattern over a wrapping address range. A registered
// read port returns memory contents with one cycle of latency.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready        write request handshake, i_wr_addr/i_wr_data payload
//   i_fill_start                 one-cycle fill command; i_fill_base/i_fill_len/i_fill_seed
//   o_busy                       FIFO non-empty or fill in progress
//   o_done                       one-cycle pulse after the final fill write
//   i_rd_addr/o_rd_data          registered read port (old data on read/write collision)
module mem_fill_writer #(
  parameter int unsigned AW         = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_fill_start,
  input  logic [AW-1:0] i_fill_base,
  input  logic [AW-1:0] i_fill_len,
  input  logic [DW-1:0] i_fill_seed,
  output logic          o_busy,
  output logic          o_done,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StDrain, StFill} state_e;

  state_e        r_state;
  logic [DW-1:0] r_mem [Depth];
  logic [DW-1:0] r_rd_data;
  logic          r_done;

  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;

  logic [AW-1:0] r_fill_addr;
  logic [DW-1:0] r_fill_data;
  logic [AW:0]   r_fill_rem;

  logic [PW:0]   w_count;
  logic [PW:0]   w_count_next;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_fill_go;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign w_count      = r_wptr - r_rptr;
  assign w_full       = (w_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty      = (r_wptr == r_rptr);
  assign o_wr_ready   = !i_rst && !w_full && (r_state != StFill);
  assign w_push       = i_wr_valid && o_wr_ready;
  assign w_pop        = !w_empty && (r_state != StFill);
  assign w_count_next = w_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
  // A fill may only start from a completely quiet block.
  assign w_fill_go    = i_fill_start && (r_state == StIdle) && w_empty && !w_push;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == StFill) begin
      w_we    = 1'b1;
      w_waddr = r_fill_addr;
      w_wdata = r_fill_data;
    end else if (w_pop) begin
      w_we    = 1'b1;
      w_waddr = r_fifo_addr[r_rptr[PW-1:0]];
      w_wdata = r_fifo_data[r_rptr[PW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_data[i] <= '0;
      end
      r_state     <= StIdle;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
      r_fill_rem  <= '0;
    end else begin
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
      // Reads the pre-write array, so a colliding write returns the old word.
      r_rd_data <= r_mem[i_rd_addr];

      if (w_push) begin
        r_fifo_addr[r_wptr[PW-1:0]] <= i_wr_addr;
        r_fifo_data[r_wptr[PW-1:0]] <= i_wr_data;
        r_wptr                      <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      r_done <= 1'b0;
      unique case (r_state)
        StFill: begin
          r_fill_addr <= r_fill_addr + 1'b1;
          r_fill_data <= r_fill_data + 1'b1;
          r_fill_rem  <= r_fill_rem - 1'b1;
          if (r_fill_rem == (AW+1)'(1)) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (w_fill_go) begin
            r_fill_addr <= i_fill_base;
            r_fill_data <= i_fill_seed;
            r_fill_rem  <= (i_fill_len == '0) ? (AW+1)'(Depth) : {1'b0, i_fill_len};
            r_state     <= StFill;
          end else begin
            r_state <= (w_count_next != '0) ? StDrain : StIdle;
          end
        end
      endcase
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_done    = r_done;
  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_mem_fill_writer.sv
`timescale 1ns/100ps
module tb_mem_fill_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       fill_start = 1'b0;
  logic [3:0] fill_base = '0;
  logic [3:0] fill_len = '0;
  logic [7:0] fill_seed = '0;
  logic       busy;
  logic       done;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;

  logic       rd_req = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [3:0] addr_q[$];

  mem_fill_writer #(.AW(4), .DW(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_fill_start(fill_start),
    .i_fill_base(fill_base), .i_fill_len(fill_len), .i_fill_seed(fill_seed),
    .o_busy(busy), .o_done(done), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue the expected word; the monitor compares it one edge later.
  task automatic read_exp(input logic [3:0] a, input logic [7:0] e);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (busy && k < max_cycles) begin
      tick();
      k++;
    end
    chk("busy_falls", {31'd0, busy}, 32'd0);
  endtask

  // Read monitor: pops the scoreboard on every read that lands.
  initial begin
    logic [3:0] a;
    logic [7:0] e;
    logic [3:0] ea;
    forever begin
      @(posedge clk);
      if (rd_req) begin
        a = rd_addr;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: addr 0x%0h no expected entry", a);
        end else begin
          e  = exp_q.pop_front();
          ea = addr_q.pop_front();
          if (rd_data !== e || ea !== a) begin
            n_fail++;
            $display("FAIL rd_data[0x%0h]: got 0x%0h expected 0x%0h", a, rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int occ;
    logic exp_rdy;
    logic [7:0] pa [6];
    pa[0] = 8'h21; pa[1] = 8'h42; pa[2] = 8'h63;
    pa[3] = 8'h84; pa[4] = 8'hA5; pa[5] = 8'hC6;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, wr_ready}, 1);
    for (int a = 0; a < 16; a++) read_exp(4'(a), 8'h00);

    // Back-to-back pushes with a duplicate address
    wr_valid = 1'b1;
    wr_addr = 4'h3; wr_data = 8'hA5; chk("push0_ready", {31'd0, wr_ready}, 1); tick();
    chk("busy_after_push", {31'd0, busy}, 1);
    wr_addr = 4'h7; wr_data = 8'h3C; chk("push1_ready", {31'd0, wr_ready}, 1); tick();
    wr_addr = 4'h3; wr_data = 8'h11; chk("push2_ready", {31'd0, wr_ready}, 1); tick();
    wr_valid = 1'b0;
    wait_idle(20);
    read_exp(4'h3, 8'h11);
    read_exp(4'h7, 8'h3C);

    // Six pushes with wr_valid held; pops drain one per cycle
    occ = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 4'(8 + i);
      wr_data = pa[i];
      exp_rdy = (occ < 4);
      chk("stream_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
      occ = occ + (exp_rdy ? 1 : 0) - ((occ > 0) ? 1 : 0);
      tick();
    end
    wr_valid = 1'b0;
    wait_idle(20);
    for (int i = 0; i < 6; i++) read_exp(4'(8 + i), pa[i]);

    // Fill E..1 with FE, FF, 00, 01
    fill_base = 4'hE; fill_len = 4'd4; fill_seed = 8'hFE; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("fill_busy", {31'd0, busy}, 1);
    chk("fill_ready", {31'd0, wr_ready}, 0);
    chk("fill_done0", {31'd0, done}, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        chk("fill4_done_low", {31'd0, done}, 0);
        chk("fill4_ready_low", {31'd0, wr_ready}, 0);
      end else begin
        chk("fill4_done_high", {31'd0, done}, 1);
        chk("fill4_busy_low", {31'd0, busy}, 0);
      end
    end
    tick();
    chk("fill4_done_pulse", {31'd0, done}, 0);
    chk("done_count_1", done_cnt, 1);
    read_exp(4'hE, 8'hFE);
    read_exp(4'hF, 8'hFF);
    read_exp(4'h0, 8'h00);
    read_exp(4'h1, 8'h01);

    // Full-range fill from base 3, seed 0x10
    fill_base = 4'h3; fill_len = 4'd0; fill_seed = 8'h10; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("fill16_done", {31'd0, done}, (k == 16) ? 32'd1 : 32'd0);
    end
    chk("done_count_2", done_cnt, 2);
    for (int a = 0; a < 16; a++) read_exp(4'(a), 8'h10 + 8'((a - 3) & 15));

    // Variant A: fill_start while FIFO holds an entry is ignored
    wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    fill_base = 4'h0; fill_len = 4'd2; fill_seed = 8'hEE; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("varA_busy", {31'd0, busy}, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("varA_no_done", done_cnt, 2);
    read_exp(4'h5, 8'h77);
    read_exp(4'h6, 8'h13);
    read_exp(4'h0, 8'h1D);

    // Variant C: read and write colliding on address 5
    wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 8'h55;
    tick();
    wr_valid = 1'b0;
    read_exp(4'h5, 8'h77);
    read_exp(4'h5, 8'h55);

    // Variant B: reset two cycles into a len=8 fill
    fill_base = 4'h0; fill_len = 4'd8; fill_seed = 8'h40; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("varB_busy", {31'd0, busy}, 0);
    chk("varB_done", {31'd0, done}, 0);
    chk("varB_ready", {31'd0, wr_ready}, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("varB_no_done", done_cnt, 2);
    for (int a = 0; a < 16; a++) read_exp(4'(a), 8'h00);

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
